// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit.
// Supports SHR, SHRA, SHL, ROR and ROL on a WIDTH-bit operand, moving at most
// STEP bit positions per clock. Requests and results use valid/ready
// handshakes, and each result carries zero and carry flags.
module shift_rotate_unit #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_count,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [2:0] MODE_SHR  = 3'b000;
    localparam logic [2:0] MODE_SHRA = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;

    // The step size is held one bit wider than the count because STEP may
    // equal WIDTH, which does not fit in CW bits.
    localparam logic [CW:0] STEP_W = (CW + 1)'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       mode_q;
    logic [CW-1:0]    remaining_q;
    logic             carry_q;

    logic [CW:0]      step_amt;
    logic [CW-1:0]    remaining_next;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;
    logic             accept;

    assign accept = (state_q == IDLE) && in_valid;

    // Pick this cycle's step size: min(remaining, STEP).
    always_comb begin
        step_amt = {1'b0, remaining_q};
        if ({1'b0, remaining_q} > STEP_W) begin
            step_amt = STEP_W;
        end
        remaining_next = remaining_q - step_amt[CW-1:0];
    end

    // Apply one step to the working register.
    // The step is built as a mux of constant shifts of 1..STEP bits, not as a
    // full barrel shifter. This keeps the shifter size bounded by STEP.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        step_data  = data_q;
        step_carry = 1'b0;
        for (int k = 1; k <= STEP; k++) begin
            if (step_amt == (CW + 1)'(k)) begin
                case (mode_q)
                    MODE_SHR: begin
                        step_data  = data_q >> k;
                        step_carry = data_q[k-1];
                    end
                    MODE_SHRA: begin
                        step_data  = $signed(data_q) >>> k;
                        step_carry = data_q[k-1];
                    end
                    MODE_SHL: begin
                        step_data  = data_q << k;
                        step_carry = data_q[WIDTH-k];
                    end
                    MODE_ROR: begin
                        step_data  = (data_q >> k) | (data_q << (WIDTH - k));
                        step_carry = data_q[k-1];
                    end
                    MODE_ROL: begin
                        step_data  = (data_q << k) | (data_q >> (WIDTH - k));
                        step_carry = data_q[WIDTH-k];
                    end
                    default: begin
                        step_data  = data_q;
                        step_carry = 1'b0;
                    end
                endcase
            end
        end
    end

    // Next-state logic for the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if ((in_count == '0) || (in_mode > MODE_ROL)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (remaining_next == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples its pre-edge inputs.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latch on acceptance, then update once per shift step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            mode_q      <= '0;
            remaining_q <= '0;
            carry_q     <= 1'b0;
        end else if (accept) begin
            data_q      <= in_data;
            mode_q      <= in_mode;
            remaining_q <= in_count;
            carry_q     <= 1'b0;
        end else if (state_q == SHIFT) begin
            data_q      <= step_data;
            carry_q     <= step_carry;
            remaining_q <= remaining_next;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_zero  = ~|data_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed testbench for shift_rotate_unit.
// Two instances are tested: WIDTH=32/STEP=4 and WIDTH=8/STEP=1.
// The bench drives and samples on the falling clock edge. Latency is the
// number of rising edges after the acceptance edge until out_valid is seen.
module tb_shift_rotate_unit;

    logic clk = 1'b0;
    logic rst_n;

    // 32-bit, STEP=4 instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_count;
    logic [2:0]  a_in_mode;
    logic        a_out_carry, a_out_zero;

    // 8-bit, STEP=1 instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_count;
    logic [2:0]  b_in_mode;
    logic        b_out_carry, b_out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_count(a_in_count), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_carry(a_out_carry), .out_zero(a_out_zero)
    );

    shift_rotate_unit #(.WIDTH(8), .STEP(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_count(b_in_count), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_carry(b_out_carry), .out_zero(b_out_zero)
    );

    // Issue one request to the 32-bit unit and wait for out_valid.
    // Returns the latency, or -1 if out_valid never arrives.
    task automatic start32(input logic [31:0] d, input logic [4:0] c,
                           input logic [2:0] m, output int lat);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_count = c; a_in_mode = m;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!a_out_valid) lat = -1;
    endtask

    task automatic finish32();
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_out_ready = 1'b0;
    endtask

    task automatic start8(input logic [7:0] d, input logic [2:0] c,
                          input logic [2:0] m, output int lat);
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = d; b_in_count = c; b_in_mode = m;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!b_out_valid) lat = -1;
    endtask

    task automatic finish8();
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 32'h0 ||
            a_out_carry !== 1'b0 || a_out_zero !== 1'b1) begin
            errors++;
            $display("FAIL reset32 got rdy=%b vld=%b data=%h c=%b z=%b exp 1 0 0 0 1",
                     a_in_ready, a_out_valid, a_out_data, a_out_carry, a_out_zero);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 8'h0 ||
            b_out_carry !== 1'b0 || b_out_zero !== 1'b1) begin
            errors++;
            $display("FAIL reset8 got rdy=%b vld=%b data=%h c=%b z=%b exp 1 0 0 0 1",
                     b_in_ready, b_out_valid, b_out_data, b_out_carry, b_out_zero);
        end
    endtask

    task automatic test_ror();
        int lat;
        start32(32'h0000_00F1, 5'd4, 3'b011, lat);
        checks++;
        if (a_out_data !== 32'h1000_000F || a_out_carry !== 1'b0 || lat != 1) begin
            errors++;
            $display("FAIL ror got data=%h c=%b lat=%0d exp 1000000f 0 1",
                     a_out_data, a_out_carry, lat);
        end
        finish32();
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake_idle got rdy=%b vld=%b exp 1 0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_shra();
        int lat;
        start32(32'h8000_0000, 5'd31, 3'b001, lat);
        checks++;
        if (a_out_data !== 32'hFFFF_FFFF || a_out_carry !== 1'b0 ||
            a_out_zero !== 1'b0 || lat != 8) begin
            errors++;
            $display("FAIL shra got data=%h c=%b z=%b lat=%0d exp ffffffff 0 0 8",
                     a_out_data, a_out_carry, a_out_zero, lat);
        end
        finish32();
    endtask

    task automatic test_shl_rol();
        int lat;
        start32(32'h0000_0003, 5'd31, 3'b010, lat);
        checks++;
        if (a_out_data !== 32'h8000_0000 || a_out_carry !== 1'b1 || lat != 8) begin
            errors++;
            $display("FAIL shl got data=%h c=%b lat=%0d exp 80000000 1 8",
                     a_out_data, a_out_carry, lat);
        end
        finish32();
        start32(32'hDEAD_BEEF, 5'd8, 3'b100, lat);
        checks++;
        if (a_out_data !== 32'hADBE_EFDE || a_out_carry !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL rol got data=%h c=%b lat=%0d exp adbeefde 0 2",
                     a_out_data, a_out_carry, lat);
        end
        finish32();
    endtask

    task automatic test_passthrough();
        int lat;
        start32(32'h1234_5678, 5'd0, 3'b000, lat);
        checks++;
        if (a_out_data !== 32'h1234_5678 || a_out_carry !== 1'b0 || lat != 0) begin
            errors++;
            $display("FAIL count0 got data=%h c=%b lat=%0d exp 12345678 0 0",
                     a_out_data, a_out_carry, lat);
        end
        finish32();
        start32(32'hA5A5_A5A5, 5'd5, 3'b111, lat);
        checks++;
        if (a_out_data !== 32'hA5A5_A5A5 || a_out_carry !== 1'b0 || lat != 0) begin
            errors++;
            $display("FAIL illegal got data=%h c=%b lat=%0d exp a5a5a5a5 0 0",
                     a_out_data, a_out_carry, lat);
        end
        finish32();
    endtask

    task automatic test_shr_zero();
        int lat;
        start32(32'h0000_000F, 5'd4, 3'b000, lat);
        checks++;
        if (a_out_data !== 32'h0 || a_out_zero !== 1'b1 || a_out_carry !== 1'b1 || lat != 1) begin
            errors++;
            $display("FAIL shr_zero got data=%h z=%b c=%b lat=%0d exp 0 1 1 1",
                     a_out_data, a_out_zero, a_out_carry, lat);
        end
        finish32();
        start32(32'h8000_0001, 5'd5, 3'b000, lat);
        checks++;
        if (a_out_data !== 32'h0400_0000 || a_out_carry !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL shr5 got data=%h c=%b lat=%0d exp 04000000 0 2",
                     a_out_data, a_out_carry, lat);
        end
        finish32();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        start32(32'h0000_0100, 5'd4, 3'b000, lat);
        // While the result is held, present a new request. It must stay pending.
        a_in_valid = 1'b1; a_in_data = 32'h0000_00F1; a_in_count = 5'd4; a_in_mode = 3'b011;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 ||
                a_out_data !== 32'h0000_0010 || a_out_carry !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || lat != 1) begin
            errors++;
            $display("FAIL backpressure_hold got %0d bad cycles lat=%0d data=%h exp 0 1 00000010",
                     bad, lat, a_out_data);
        end
        finish32();
        // Handshake edge done; unit is IDLE with the request still held.
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_idle got rdy=%b vld=%b exp 1 0", a_in_ready, a_out_valid);
        end
        @(posedge clk);   // acceptance edge
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pending_accept got rdy=%b vld=%b exp 0 0", a_in_ready, a_out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'h1000_000F) begin
            errors++;
            $display("FAIL pending_result got vld=%b data=%h exp 1 1000000f",
                     a_out_valid, a_out_data);
        end
        finish32();
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 32'hFFFF_0000; a_in_count = 5'd20; a_in_mode = 3'b000;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 32'h0 ||
            a_out_zero !== 1'b1 || a_out_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_shift got rdy=%b vld=%b data=%h z=%b c=%b exp 1 0 0 1 0",
                     a_in_ready, a_out_valid, a_out_data, a_out_zero, a_out_carry);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start32(32'h0000_0001, 5'd1, 3'b011, lat);
        checks++;
        if (a_out_data !== 32'h8000_0000 || a_out_carry !== 1'b1 || lat != 1) begin
            errors++;
            $display("FAIL ror_after_reset got data=%h c=%b lat=%0d exp 80000000 1 1",
                     a_out_data, a_out_carry, lat);
        end
        finish32();
    endtask

    task automatic test_w8_step1();
        int lat;
        start8(8'h81, 3'd1, 3'b011, lat);
        checks++;
        if (b_out_data !== 8'hC0 || b_out_carry !== 1'b1 || lat != 1) begin
            errors++;
            $display("FAIL w8_ror got data=%h c=%b lat=%0d exp c0 1 1", b_out_data, b_out_carry, lat);
        end
        finish8();
        start8(8'h96, 3'd3, 3'b100, lat);
        checks++;
        if (b_out_data !== 8'hB4 || b_out_carry !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL w8_rol got data=%h c=%b lat=%0d exp b4 0 3", b_out_data, b_out_carry, lat);
        end
        finish8();
        // Reset the 8-bit unit part-way through a 7-step operation.
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = 8'hFF; b_in_count = 3'd7; b_in_mode = 3'b000;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 8'h0) begin
            errors++;
            $display("FAIL w8_reset got rdy=%b vld=%b data=%h exp 1 0 00",
                     b_in_ready, b_out_valid, b_out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start8(8'h81, 3'd1, 3'b011, lat);
        checks++;
        if (b_out_data !== 8'hC0 || b_out_carry !== 1'b1 || lat != 1) begin
            errors++;
            $display("FAIL w8_ror_after_reset got data=%h c=%b lat=%0d exp c0 1 1",
                     b_out_data, b_out_carry, lat);
        end
        finish8();
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_count = '0; a_in_mode = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_count = '0; b_in_mode = '0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_ror();
        test_shra();
        test_shl_rol();
        test_passthrough();
        test_shr_zero();
        test_backpressure();
        test_reset_mid_shift();
        test_w8_step1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
